// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared pipeline defines for the write-back / register-file slice.
//   Holds the control-level encodings (reset, write and read enables), the
//   canonical zero word, the no-op register address and the default bus
//   widths used as parameter defaults by wb_regfile and its MEM/WB latch.
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

    // Control-level encodings
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Bus geometry
    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    // Canonical constants
    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_mem_wb.sv
// ---------------------------------------------------------------------------
// wb_regfile_mem_wb
//   MEM/WB pipeline latch. Captures the MEM stage's write-back triple on each
//   rising edge. Priority: flush (load a bubble) > stall (hold) > load.
//
// Ports
//   clk        in   pipeline clock
//   rst        in   asynchronous active-high reset (clears the latch)
//   stall      in   hold the current latch contents
//   flush      in   replace the latch contents with a bubble
//   mem_wd     in   destination register from MEM
//   mem_wreg   in   write enable from MEM
//   mem_wdata  in   write data from MEM
//   wb_wd      out  latched destination register
//   wb_wreg    out  latched write enable
//   wb_wdata   out  latched write data
// ---------------------------------------------------------------------------
module wb_regfile_mem_wb
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    logic [ADDR_W-1:0] wd_q,    wd_d;
    logic              wreg_q,  wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        // NOTE: every output of this block gets a default first (hold), so no
        // path leaves a signal unassigned and no latch is inferred.
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (flush) begin
            wd_d    = NOP_REG_ADDR;
            wreg_d  = WRITE_DISABLE;
            wdata_d = ZERO_WORD;
        end else if (!stall) begin
            wd_d    = mem_wd;
            wreg_d  = mem_wreg;
            wdata_d = mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb_wd    = wd_q;
    assign wb_wreg  = wreg_q;
    assign wb_wdata = wdata_q;

endmodule : wb_regfile_mem_wb

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the integer pipeline. Latches the MEM stage's
//   write-back triple (MEM/WB latch), commits the latched write into the
//   general-purpose register array on the following edge, and serves two
//   combinational decode read ports that bypass the not-yet-committed
//   write-back value. Register 0 always reads as zero.
//
// Ports
//   clk               in   pipeline clock
//   rst               in   asynchronous active-high reset
//   stall, flush      in   MEM/WB latch control (flush wins)
//   mem_wd/wreg/wdata in   write-back triple from MEM
//   re1, raddr1       in   read port 1 enable / address
//   re2, raddr2       in   read port 2 enable / address
//   rdata1, rdata2    out  read data (combinational)
//   wb_wd/wreg/wdata  out  latched write-back triple
// ---------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int NUM_REGS = REG_NUM,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    // True when the address space is larger than the register count, so some
    // addresses name no register and must be filtered.
    localparam bit SPARSE_ADDR = (NUM_REGS < (1 << ADDR_W));

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // -----------------------------------------------------------------------
    // MEM/WB latch
    // -----------------------------------------------------------------------
    wb_regfile_mem_wb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
    );

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        if (SPARSE_ADDR) begin
            return int'(addr) < NUM_REGS;
        end
        return 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Array write: commits whatever the latch held before this edge, so a
    // flush or stall in the same cycle never cancels it.
    // -----------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (wb_wreg == WRITE_ENABLE && wb_wd != NOP_REG_ADDR && addr_in_range(wb_wd)) begin
            regs_d[wb_wd] = wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the register array is built from reset flops rather than a RAM
        // macro because the architecture requires every entry to clear on rst.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. The bypass term returns the write sitting in the latch, which
    // the array only absorbs at the next edge.
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_i,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              byp_wreg,
        input logic [ADDR_W-1:0] byp_wd,
        input logic [DATA_W-1:0] byp_wdata,
        input logic [DATA_W-1:0] arr_val
    );
        if (rst_i == RST_ENABLE)                                return '0;
        if (re == READ_DISABLE)                                 return '0;
        if (raddr == NOP_REG_ADDR)                              return '0;
        if (!addr_in_range(raddr))                              return '0;
        if (byp_wreg == WRITE_ENABLE && raddr == byp_wd)        return byp_wdata;
        return arr_val;
    endfunction

    logic [DATA_W-1:0] arr_rd1;
    logic [DATA_W-1:0] arr_rd2;

    always_comb begin
        arr_rd1 = '0;
        arr_rd2 = '0;
        if (addr_in_range(raddr1)) begin
            arr_rd1 = regs_q[raddr1];
        end
        if (addr_in_range(raddr2)) begin
            arr_rd2 = regs_q[raddr2];
        end
    end

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, arr_rd1);
        rdata2 = read_port(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, arr_rd2);
    end

    // READ_ENABLE documents the active level of re1/re2; READ_DISABLE is the
    // value tested above.
    logic unused_read_enable;
    assign unused_read_enable = READ_ENABLE;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. An architectural model tracks the
//   register values the program can observe (a write becomes visible as soon
//   as it sits in write-back) and the expected latch contents; a compare
//   process checks every output against it on each falling edge. Directed
//   sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic          re1, re2;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2;
    logic [AW-1:0] wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata;

    int checks   = 0;
    int failures = 0;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Architectural model
    // -----------------------------------------------------------------------
    logic [DW-1:0] m_arch [NR];
    logic [AW-1:0] m_wd    = '0;
    logic          m_wreg  = 1'b0;
    logic [DW-1:0] m_wdata = '0;

    initial begin
        for (int i = 0; i < NR; i++) m_arch[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
            for (int i = 0; i < NR; i++) m_arch[i] = '0;
        end else begin
            if (flush) begin
                m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
            end else if (!stall) begin
                m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata;
            end
            if (m_wreg && m_wd != 0) m_arch[m_wd] = m_wdata;
        end
    end

    function automatic logic [DW-1:0] exp_read(input logic en, input logic [AW-1:0] a);
        if (rst || !en || a == 0) return '0;
        return m_arch[a];
    endfunction

    always @(negedge clk) begin
        check("cmp_wb_wd",    32'(wb_wd),    32'(m_wd));
        check("cmp_wb_wreg",  32'(wb_wreg),  32'(m_wreg));
        check("cmp_wb_wdata", wb_wdata,      m_wdata);
        check("cmp_rdata1",   rdata1,        exp_read(re1, raddr1));
        check("cmp_rdata2",   rdata2,        exp_read(re2, raddr2));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        check("rst_wb_wd",    32'(wb_wd),   32'd0);
        check("rst_wb_wreg",  32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata,     32'd0);
        check("rst_rdata1",   rdata1,       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Fill regs 1..31, then reset mid-cycle with reg31 still pending.
        for (int i = 1; i < NR; i++) begin
            mem_wd = AW'(i); mem_wreg = 1'b1; mem_wdata = 32'hA500_0000 | 32'(i);
            step();
        end
        mem_wreg = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        check("fill_r5",        rdata1, 32'hA500_0005);
        check("fill_r31_bypass", rdata2, 32'hA500_001F);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wb_wd",    32'(wb_wd),   32'd0);
        check("midrst_wb_wreg",  32'(wb_wreg), 32'd0);
        check("midrst_wb_wdata", wb_wdata,     32'd0);
        check("midrst_rdata1",   rdata1,       32'd0);
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        #1;
        check("postrst_r5",  rdata1, 32'd0);
        check("postrst_r31", rdata2, 32'd0);

        // Write then read through the bypass, then from the array.
        mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
        step();
        mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = '0; raddr1 = 5'd3; re1 = 1'b1;
        #1;
        check("wr_wb_wd",     32'(wb_wd), 32'd3);
        check("wr_bypass_r3", rdata1,     32'hDEAD_BEEF);
        step();
        #1;
        check("wr_array_r3",  rdata1,     32'hDEAD_BEEF);
        step();
        #1;
        check("wr_array_r3b", rdata1,     32'hDEAD_BEEF);

        // Register zero ignores writes, including the bypass cycle.
        mem_wd = 5'd0; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
        raddr1 = 5'd0; raddr2 = 5'd0; re1 = 1'b1; re2 = 1'b1;
        step();
        mem_wreg = 1'b0;
        #1;
        check("r0_wb_wreg",  32'(wb_wreg), 32'd1);
        check("r0_byp_rd1",  rdata1,       32'd0);
        check("r0_byp_rd2",  rdata2,       32'd0);
        step();
        #1;
        check("r0_arr_rd1",  rdata1,       32'd0);

        // Stall holds the latch; flush beats stall.
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h0000_00AA;
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_wd = AW'(10 + k); mem_wdata = 32'h5500_0000 + 32'(k);
            step();
            #1;
            check("stall_wb_wd",    32'(wb_wd), 32'd7);
            check("stall_wb_wdata", wb_wdata,   32'h0000_00AA);
        end
        flush = 1'b1;
        step();
        #1;
        check("flush_wb_wreg", 32'(wb_wreg), 32'd0);
        check("flush_wb_wd",   32'(wb_wd),   32'd0);
        flush = 1'b0; stall = 1'b0; mem_wreg = 1'b0; raddr1 = 5'd7;
        #1;
        check("flush_r7", rdata1, 32'h0000_00AA);

        // Read enables and both ports on one address.
        mem_wd = 5'd4; mem_wreg = 1'b1; mem_wdata = 32'h11;
        step();
        mem_wd = 5'd9; mem_wdata = 32'h22;
        step();
        mem_wreg = 1'b0;
        step();
        step();
        re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b0; raddr2 = 5'd9;
        #1;
        check("re_rd1",     rdata1, 32'h11);
        check("re_rd2_off", rdata2, 32'h0);
        re2 = 1'b1;
        #1;
        check("re_rd2_on",  rdata2, 32'h22);
        raddr2 = 5'd4;
        #1;
        check("dual_rd1",   rdata1, 32'h11);
        check("dual_rd2",   rdata2, 32'h11);
        step();

        // Back-to-back writes to the same register.
        raddr1 = 5'd6;
        mem_wd = 5'd6; mem_wreg = 1'b1; mem_wdata = 32'h1;
        step();
        mem_wdata = 32'h2;
        #1;
        check("b2b_first",  rdata1, 32'h1);
        step();
        mem_wreg = 1'b0;
        #1;
        check("b2b_second", rdata1, 32'h2);
        step();
        #1;
        check("b2b_settle", rdata1, 32'h2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_regfile
